fifo_stream_reader: RTL and testbench

//  Downstream consumer of the synchronous FIFO. Pops words through the FIFO read port
//  (rd_en/data_out/empty/underflow) and presents them as a valid/ready stream (m_*).

---
 rtl/fifo_stream_reader_pkg.sv | 16 +
 rtl/stream_out_buf.sv | 50 +++++
 rtl/fifo_stream_reader.sv | 69 ++++++
 tb/tb_fifo_stream_reader.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_stream_reader_pkg.sv
// fifo_stream_reader_pkg: shared FIFO word width/type and circular index helper
// Contents:
//   FIFO_WIDTH  default FIFO data width
//   fifo_word_t FIFO data word type at the default width
//   wrap_inc    increment an index modulo an arbitrary (non power-of-two) depth
package fifo_stream_reader_pkg;

    localparam int FIFO_WIDTH = 16;

    typedef logic [FIFO_WIDTH-1:0] fifo_word_t;

    function automatic int wrap_inc(input int idx, input int depth);
        return (idx == depth - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/stream_out_buf.sv
// stream_out_buf: circular output buffer of DEPTH words with occupancy tracking
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   push       write push_data at the tail this edge
//   push_data  word to store
//   pop        retire the head word this edge (only asserted while occ != 0)
//   head_data  word at the head of the buffer
//   occ        number of stored words, 0..DEPTH
module stream_out_buf
    import fifo_stream_reader_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH,
    parameter int DEPTH = 3,
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int OW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [OW-1:0]    occ
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [IW-1:0]    wr_idx;
    logic [IW-1:0]    rd_idx;

    assign head_data = mem[rd_idx];

    // Storage is cleared on reset so the head reads 0 while the buffer is empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ    <= '0;
            wr_idx <= '0;
            rd_idx <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_idx] <= push_data;
                wr_idx      <= IW'(wrap_inc(int'(wr_idx), DEPTH));
            end
            if (pop) rd_idx <= IW'(wrap_inc(int'(rd_idx), DEPTH));
            if (push && !pop) occ <= occ + OW'(1);
            else if (pop && !push) occ <= occ - OW'(1);
        end
    end

endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: pops a synchronous FIFO and presents its words as a valid/ready stream
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   empty          FIFO empty flag
//   data_out       FIFO read data, valid the cycle after an accepted rd_en
//   underflow      FIFO underflow flag
//   rd_en          FIFO pop request
//   m_valid        stream word available
//   m_data         stream word, stable while m_valid && !m_ready
//   m_ready        sink accepts m_data
//   words_out      count of stream handshakes, wraps silently
//   err_underflow  sticky underflow seen
module fifo_stream_reader #(
    parameter int FIFO_WIDTH = fifo_stream_reader_pkg::FIFO_WIDTH,
    parameter int BUF_DEPTH  = 3,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  empty,
    input  logic [FIFO_WIDTH-1:0] data_out,
    input  logic                  underflow,
    output logic                  rd_en,
    output logic                  m_valid,
    output logic [FIFO_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  words_out,
    output logic                  err_underflow
);

    localparam int OW = $clog2(BUF_DEPTH + 1);

    logic          inflight;
    logic [OW-1:0] occ;
    logic          hs;

    assign m_valid = occ != '0;
    assign hs      = m_valid && m_ready;

    // Credit check counts the word still in flight so the buffer can never overflow;
    // m_ready is deliberately kept out of this path.
    assign rd_en = !rst && !empty && (int'(occ) + int'(inflight) < BUF_DEPTH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight      <= 1'b0;
            words_out     <= '0;
            err_underflow <= 1'b0;
        end else begin
            inflight <= rd_en;
            if (hs) words_out <= words_out + CNT_WIDTH'(1);
            if (underflow) err_underflow <= 1'b1;
        end
    end

    stream_out_buf #(
        .WIDTH (FIFO_WIDTH),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data (data_out),
        .pop       (hs),
        .head_data (m_data),
        .occ       (occ)
    );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: directed self-checking bench for fifo_stream_reader with a FIFO model
module tb_fifo_stream_reader;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          empty;
    logic [W-1:0]  data_out = '0;
    logic          underflow;
    logic          rd_en;
    logic          m_valid;
    logic [W-1:0]  m_data;
    logic          m_ready = 1'b0;
    logic [31:0]   words_out;
    logic          err_underflow;
    logic          uf_force = 1'b0;

    int checks   = 0;
    int failures = 0;

    fifo_stream_reader #(.FIFO_WIDTH(W), .BUF_DEPTH(3), .CNT_WIDTH(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .empty         (empty),
        .data_out      (data_out),
        .underflow     (underflow),
        .rd_en         (rd_en),
        .m_valid       (m_valid),
        .m_data        (m_data),
        .m_ready       (m_ready),
        .words_out     (words_out),
        .err_underflow (err_underflow)
    );

    always #5 clk = ~clk;

    // FIFO model: one-cycle read latency, pops only when not empty
    logic [W-1:0] mem [0:255];
    int pushed = 0;
    int popped = 0;
    assign empty     = (pushed == popped);
    assign underflow = uf_force || (rd_en && empty);

    always @(posedge clk) begin
        if (rd_en && !empty) begin
            data_out <= mem[popped[7:0]];
            popped   <= popped + 1;
        end
    end

    // Stream monitor
    logic [W-1:0] got[$];
    int beat_cyc[$];
    int cyc = 0;
    int rd_cnt = 0;
    int max_occ = 0;
    bit rd_empty = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst) begin
            if (m_valid && m_ready) begin
                got.push_back(m_data);
                beat_cyc.push_back(cyc);
            end
            if (rd_en) rd_cnt++;
            if (rd_en && empty) rd_empty = 1'b1;
            if (int'(dut.u_buf.occ) > max_occ) max_occ = int'(dut.u_buf.occ);
        end
    end

    task automatic push_word(input logic [W-1:0] v);
        mem[pushed[7:0]] = v;
        pushed++;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        m_ready = 1'b0;
        for (int i = 1; i <= 8; i++) push_word(W'(i));
        repeat (2) @(posedge clk);
        #1;
        checks++; if (rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en got=%0b exp=0", rd_en); end
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid got=%0b exp=0", m_valid); end
        checks++; if (m_data !== 16'h0000) begin failures++; $display("FAIL reset_m_data got=%h exp=0000", m_data); end
        checks++; if (words_out !== 32'd0) begin failures++; $display("FAIL reset_words_out got=%0d exp=0", words_out); end
        checks++; if (err_underflow !== 1'b0) begin failures++; $display("FAIL reset_err_underflow got=%0b exp=0", err_underflow); end
    endtask

    task automatic test_stream;
        bit ok = 1'b1;
        got.delete();
        beat_cyc.delete();
        @(negedge clk);
        m_ready = 1'b1;
        rst = 1'b0;
        #1;
        checks++; if (rd_en !== 1'b1) begin failures++; $display("FAIL stream_first_rd_en got=%0b exp=1", rd_en); end
        @(posedge clk); #1;
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL stream_valid_edge1 got=%0b exp=0", m_valid); end
        @(posedge clk); #1;
        checks++; if (m_valid !== 1'b1 || m_data !== 16'h0001) begin failures++; $display("FAIL stream_valid_edge2 got=%0b/%h exp=1/0001", m_valid, m_data); end
        for (int t = 0; t < 40 && got.size() < 8; t++) begin @(posedge clk); #1; end
        checks++; if (got.size() != 8) begin failures++; $display("FAIL stream_count got=%0d exp=8", got.size()); end
        for (int i = 0; i < got.size(); i++) if (got[i] !== W'(i + 1)) ok = 1'b0;
        checks++; if (!ok) begin failures++; $display("FAIL stream_order got_first=%h exp=0001..0008", got.size() > 0 ? got[0] : 16'hxxxx); end
        checks++; if (beat_cyc.size() != 8 || beat_cyc[7] - beat_cyc[0] != 7) begin failures++; $display("FAIL stream_back_to_back got_span=%0d exp=7", beat_cyc.size() == 8 ? beat_cyc[7] - beat_cyc[0] : -1); end
        checks++; if (words_out !== 32'd8) begin failures++; $display("FAIL stream_words_out got=%0d exp=8", words_out); end
    endtask

    task automatic test_backpressure;
        int p0;
        bit held_bad = 1'b0;
        bit ok = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        m_ready = 1'b0;
        got.delete();
        for (int i = 1; i <= 8; i++) push_word(W'(i));
        p0 = popped;
        @(negedge clk);
        rst = 1'b0;
        for (int t = 0; t < 10; t++) begin
            @(posedge clk); #1;
            if (t >= 1 && (m_valid !== 1'b1 || m_data !== 16'h0001)) held_bad = 1'b1;
        end
        checks++; if (popped - p0 != 3) begin failures++; $display("FAIL bp_pops got=%0d exp=3", popped - p0); end
        checks++; if (rd_en !== 1'b0) begin failures++; $display("FAIL bp_rd_en_stalled got=%0b exp=0", rd_en); end
        checks++; if (dut.u_buf.occ !== 2'd3) begin failures++; $display("FAIL bp_occ got=%0d exp=3", dut.u_buf.occ); end
        checks++; if (held_bad) begin failures++; $display("FAIL bp_m_data_held got=%h exp=0001", m_data); end
        @(negedge clk);
        m_ready = 1'b1;
        for (int t = 0; t < 40 && got.size() < 8; t++) begin @(posedge clk); #1; end
        for (int i = 0; i < 8; i++) if (i >= got.size() || got[i] !== W'(i + 1)) ok = 1'b0;
        checks++; if (!ok || got.size() != 8) begin failures++; $display("FAIL bp_order got_count=%0d exp=8 in order", got.size()); end
        checks++; if (words_out !== 32'd8) begin failures++; $display("FAIL bp_words_out got=%0d exp=8", words_out); end
    endtask

    task automatic test_toggle;
        bit ok = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        m_ready = 1'b0;
        got.delete();
        @(negedge clk);
        rst = 1'b0;
        max_occ = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            push_word(16'h0100 + W'(i));
            m_ready = ~m_ready;
        end
        for (int t = 0; t < 60 && got.size() < 12; t++) begin
            @(negedge clk);
            m_ready = ~m_ready;
        end
        for (int i = 0; i < 12; i++) if (i >= got.size() || got[i] !== 16'h0100 + W'(i)) ok = 1'b0;
        checks++; if (!ok || got.size() != 12) begin failures++; $display("FAIL toggle_order got_count=%0d exp=12 in order", got.size()); end
        checks++; if (max_occ > 3) begin failures++; $display("FAIL toggle_max_occ got=%0d exp<=3", max_occ); end
    endtask

    task automatic test_single;
        @(negedge clk);
        rst = 1'b1;
        m_ready = 1'b1;
        got.delete();
        @(negedge clk);
        rst = 1'b0;
        rd_cnt = 0;
        rd_empty = 1'b0;
        #1;
        checks++; if (rd_en !== 1'b0) begin failures++; $display("FAIL single_rd_en_empty got=%0b exp=0", rd_en); end
        @(negedge clk);
        push_word(16'h00AA);
        #1;
        checks++; if (rd_en !== 1'b1) begin failures++; $display("FAIL single_rd_en_nonempty got=%0b exp=1", rd_en); end
        repeat (8) @(posedge clk);
        #1;
        checks++; if (rd_cnt != 1) begin failures++; $display("FAIL single_rd_pulses got=%0d exp=1", rd_cnt); end
        checks++; if (got.size() != 1 || got[0] !== 16'h00AA) begin failures++; $display("FAIL single_beat got_count=%0d exp=1 word 00aa", got.size()); end
        checks++; if (rd_empty) begin failures++; $display("FAIL single_rd_while_empty got=1 exp=0"); end
        checks++; if (words_out !== 32'd1) begin failures++; $display("FAIL single_words_out got=%0d exp=1", words_out); end
    endtask

    task automatic test_reset_midflight;
        bit ok = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        m_ready = 1'b0;
        got.delete();
        for (int i = 1; i <= 6; i++) push_word(16'h0200 + W'(i));
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (dut.u_buf.occ !== 2'd2 || dut.inflight !== 1'b1) begin failures++; $display("FAIL mid_precond got=occ%0d/inf%0b exp=occ2/inf1", dut.u_buf.occ, dut.inflight); end
        rst = 1'b1;
        #1;
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL mid_m_valid got=%0b exp=0", m_valid); end
        checks++; if (rd_en !== 1'b0) begin failures++; $display("FAIL mid_rd_en got=%0b exp=0", rd_en); end
        checks++; if (words_out !== 32'd0) begin failures++; $display("FAIL mid_words_out got=%0d exp=0", words_out); end
        @(negedge clk);
        m_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int t = 0; t < 30 && got.size() < 3; t++) begin @(posedge clk); #1; end
        checks++; if (got.size() < 1 || got[0] !== 16'h0204) begin failures++; $display("FAIL mid_head got=%h exp=0204", got.size() > 0 ? got[0] : 16'hxxxx); end
        for (int i = 0; i < 3; i++) if (i >= got.size() || got[i] !== 16'h0204 + W'(i)) ok = 1'b0;
        checks++; if (!ok || got.size() != 3) begin failures++; $display("FAIL mid_order got_count=%0d exp=3 (0204..0206)", got.size()); end
    endtask

    task automatic test_underflow_wrap;
        bit ok = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        m_ready = 1'b1;
        got.delete();
        for (int i = 1; i <= 4; i++) push_word(16'h0300 + W'(i));
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (err_underflow !== 1'b0) begin failures++; $display("FAIL uf_initial got=%0b exp=0", err_underflow); end
        @(negedge clk);
        uf_force = 1'b1;
        @(negedge clk);
        uf_force = 1'b0;
        #1;
        checks++; if (err_underflow !== 1'b1) begin failures++; $display("FAIL uf_set got=%0b exp=1", err_underflow); end
        for (int t = 0; t < 30 && got.size() < 4; t++) begin @(posedge clk); #1; end
        for (int i = 0; i < 4; i++) if (i >= got.size() || got[i] !== 16'h0300 + W'(i + 1)) ok = 1'b0;
        checks++; if (!ok || got.size() != 4) begin failures++; $display("FAIL uf_data_path got_count=%0d exp=4 in order", got.size()); end
        checks++; if (words_out !== 32'd4) begin failures++; $display("FAIL uf_words_out got=%0d exp=4", words_out); end
        @(negedge clk);
        force dut.words_out = 32'hFFFF_FFFF;
        #1;
        release dut.words_out;
        push_word(16'h0305);
        for (int t = 0; t < 20 && got.size() < 5; t++) begin @(posedge clk); #1; end
        checks++; if (words_out !== 32'd0) begin failures++; $display("FAIL wrap_words_out got=%h exp=00000000", words_out); end
        checks++; if (got.size() != 5 || got[4] !== 16'h0305) begin failures++; $display("FAIL wrap_beat got_count=%0d exp=5 last 0305", got.size()); end
        checks++; if (err_underflow !== 1'b1) begin failures++; $display("FAIL uf_sticky got=%0b exp=1", err_underflow); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (err_underflow !== 1'b0) begin failures++; $display("FAIL uf_cleared got=%0b exp=0", err_underflow); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_toggle();
        test_single();
        test_reset_midflight();
        test_underflow_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
